hermes_switch_control: RTL

//  Routing and arbitration controller for one 5-port mesh router in the manycore PE.

---
 rtl/hermes_switch_control.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hermes_switch_control.sv
// Routing and arbitration controller for one 5-port mesh router.
// Picks header requests round-robin, XY-routes them and holds
// crossbar connections until the input signals its tail has left.
//
// Ports:
//   clock, reset  : clock, asynchronous active-low reset
//   req_i[5]      : input p has a header flit at its buffer head
//   header_i      : head flit per input, slice p = [p*FLIT_WIDTH +: FLIT_WIDTH]
//   release_i[5]  : pulse, input p has forwarded its packet tail
//   ack_h_o[5]    : pulse, header of input p accepted and routed
//   out_en_o[5]   : output o connected to an input
//   out_sel_o[15] : input index driving output o, slice [o*3 +: 3]
//   in_route_o[15]: output index held by input p, slice [p*3 +: 3]
//   busy_o        : arbitration FSM not idle
// Port order: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.
module hermes_switch_control #(
   parameter int                    FLIT_WIDTH = 32,
   parameter logic [FLIT_WIDTH-1:0] ADDRESS    = '0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [4:0]              req_i,
   input  logic [5*FLIT_WIDTH-1:0] header_i,
   input  logic [4:0]              release_i,
   output logic [4:0]              ack_h_o,
   output logic [4:0]              out_en_o,
   output logic [14:0]             out_sel_o,
   output logic [14:0]             in_route_o,
   output logic                    busy_o
);

   localparam int HW = FLIT_WIDTH / 4;
   localparam int DW = FLIT_WIDTH / 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARB,
      S_ROUTE,
      S_GRANT
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [2:0]      rr_ptr;
   logic [2:0]      sel;
   logic [2:0]      target;
   logic [2:0]      pick;
   logic [2:0]      scan;
   logic [2:0]      route;
   logic            found;
   logic [DW-1:0]   hdr;
   logic [4:0]      linked;
   logic [7:0]      elig;
   logic [7:0]      en_ext;
   logic            dest_busy;
   logic [HW-1:0]   own_x;
   logic [HW-1:0]   own_y;
   logic [HW-1:0]   dst_x;
   logic [HW-1:0]   dst_y;
   logic            unused_hdr;

   // Only the destination half of each header is routed on.
   always_comb begin
      unused_hdr = 1'b0;
      for (int p = 0; p < 5; p++) begin
         unused_hdr = unused_hdr ^
            (^header_i[p*FLIT_WIDTH+DW +: FLIT_WIDTH-DW]);
      end
   end

   assign own_x  = ADDRESS[DW-1:HW];
   assign own_y  = ADDRESS[HW-1:0];
   assign dst_x  = hdr[DW-1:HW];
   assign dst_y  = hdr[HW-1:0];
   assign busy_o = (state != S_IDLE);

   // Inputs already holding a connection cannot request again.
   assign elig   = {3'b000, req_i & ~linked};
   assign en_ext = {3'b000, out_en_o};

   // Round-robin scan starting just after the last winner.
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      scan  = '0;
      for (int i = 1; i <= 5; i++) begin
         scan = 3'((32'(rr_ptr) + i) % 5);
         if (!found && elig[scan]) begin
            pick  = scan;
            found = 1'b1;
         end
      end
   end

   // XY routing: resolve X first, then Y, else deliver locally.
   always_comb begin
      route = 3'd4;
      if (dst_x > own_x) begin
         route = 3'd0;
      end else if (dst_x < own_x) begin
         route = 3'd1;
      end else if (dst_y > own_y) begin
         route = 3'd2;
      end else if (dst_y < own_y) begin
         route = 3'd3;
      end
   end

   assign dest_busy = en_ext[route];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (|elig) state_nx = S_ARB;
         end
         S_ARB: begin
            state_nx = found ? S_ROUTE : S_IDLE;
         end
         S_ROUTE: begin
            // A busy target is dropped; rr_ptr has moved on already.
            state_nx = dest_busy ? S_IDLE : S_GRANT;
         end
         S_GRANT: begin
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= 3'd4;
         sel        <= '0;
         target     <= '0;
         hdr        <= '0;
         linked     <= '0;
         ack_h_o    <= '0;
         out_en_o   <= '0;
         out_sel_o  <= '0;
         in_route_o <= '0;
      end else begin
         ack_h_o <= '0;

         // Tail releases run independently of the FSM.
         for (int p = 0; p < 5; p++) begin
            if (release_i[p] && linked[p]) begin
               linked[p] <= 1'b0;
               for (int o = 0; o < 5; o++) begin
                  if (in_route_o[p*3 +: 3] == 3'(o)) begin
                     out_en_o[o] <= 1'b0;
                  end
               end
            end
         end

         unique case (state)
            S_ARB: begin
               if (found) begin
                  rr_ptr <= pick;
                  sel    <= pick;
                  for (int p = 0; p < 5; p++) begin
                     if (pick == 3'(p)) begin
                        hdr <= header_i[p*FLIT_WIDTH +: DW];
                     end
                  end
               end
            end
            S_ROUTE: begin
               target <= route;
            end
            S_GRANT: begin
               // Target was free in ROUTE and releases only free
               // outputs, so no other input can own it here.
               for (int o = 0; o < 5; o++) begin
                  if (target == 3'(o)) begin
                     out_en_o[o]         <= 1'b1;
                     out_sel_o[o*3 +: 3] <= sel;
                  end
               end
               for (int p = 0; p < 5; p++) begin
                  if (sel == 3'(p)) begin
                     in_route_o[p*3 +: 3] <= target;
                     linked[p]            <= 1'b1;
                     ack_h_o[p]           <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
